// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: two producer FIFOs (EXU, LSU) merged by a round-robin arbiter
// into a registered GPR write port, with a combinational pending-write query.
module ysyx_25060170_wbu #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid_i,
    output logic        exu_ready_o,
    input  logic        exu_wen_i,
    input  logic [4:0]  exu_rd_i,
    input  logic [31:0] exu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_wen_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        gpr_we_o,
    output logic [4:0]  gpr_waddr_o,
    output logic [31:0] gpr_wdata_o,
    input  logic [4:0]  query_r1_i,
    input  logic [4:0]  query_r2_i,
    output logic        pend1_o,
    output logic        pend2_o,
    output logic [31:0] commit_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic SEL_EXU = 1'b0;
    localparam logic SEL_LSU = 1'b1;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          exu_mem [DEPTH];
    entry_t          lsu_mem [DEPTH];
    logic [PW-1:0]   exu_wp, exu_rp, lsu_wp, lsu_rp;
    logic [CW-1:0]   exu_cnt, lsu_cnt;
    logic            last_sel;
    logic            push_exu, push_lsu, pop_exu, pop_lsu;
    logic [DEPTH-1:0] exu_live, lsu_live;
    entry_t          head;

    // Ready ignores a same-cycle pop, so a full FIFO never accepts.
    assign exu_ready_o = (exu_cnt != FULL) & ~rst;
    assign lsu_ready_o = (lsu_cnt != FULL) & ~rst;
    assign push_exu    = exu_valid_i & exu_ready_o;
    assign push_lsu    = lsu_valid_i & lsu_ready_o;

    assign pop_lsu = (lsu_cnt != '0) & ((exu_cnt == '0) | (last_sel == SEL_EXU));
    assign pop_exu = (exu_cnt != '0) & ~pop_lsu;
    assign head    = pop_lsu ? lsu_mem[lsu_rp] : exu_mem[exu_rp];

    always_ff @(posedge clk) begin
        if (push_exu) exu_mem[exu_wp] <= '{exu_wen_i, exu_rd_i, exu_data_i};
        if (push_lsu) lsu_mem[lsu_wp] <= '{lsu_wen_i, lsu_rd_i, lsu_data_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exu_wp  <= '0;
            exu_rp  <= '0;
            exu_cnt <= '0;
        end else begin
            if (push_exu) exu_wp <= exu_wp + PW'(1);
            if (pop_exu)  exu_rp <= exu_rp + PW'(1);
            case ({push_exu, pop_exu})
                2'b10:   exu_cnt <= exu_cnt + CW'(1);
                2'b01:   exu_cnt <= exu_cnt - CW'(1);
                default: exu_cnt <= exu_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_wp  <= '0;
            lsu_rp  <= '0;
            lsu_cnt <= '0;
        end else begin
            if (push_lsu) lsu_wp <= lsu_wp + PW'(1);
            if (pop_lsu)  lsu_rp <= lsu_rp + PW'(1);
            case ({push_lsu, pop_lsu})
                2'b10:   lsu_cnt <= lsu_cnt + CW'(1);
                2'b01:   lsu_cnt <= lsu_cnt - CW'(1);
                default: lsu_cnt <= lsu_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sel     <= SEL_EXU;
            gpr_we_o     <= 1'b0;
            gpr_waddr_o  <= '0;
            gpr_wdata_o  <= '0;
            commit_cnt_o <= '0;
        end else if (pop_exu | pop_lsu) begin
            last_sel     <= pop_lsu ? SEL_LSU : SEL_EXU;
            gpr_we_o     <= head.wen & (head.rd != 5'd0);
            gpr_waddr_o  <= head.rd;
            gpr_wdata_o  <= head.data;
            commit_cnt_o <= commit_cnt_o + 32'd1;
        end else begin
            gpr_we_o     <= 1'b0;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        exu_live = '0;
        lsu_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exu_live[i] = {1'b0, PW'(i) - exu_rp} < exu_cnt;
            lsu_live[i] = {1'b0, PW'(i) - lsu_rp} < lsu_cnt;
        end
    end

    always_comb begin
        pend1_o = gpr_we_o & (gpr_waddr_o == query_r1_i);
        pend2_o = gpr_we_o & (gpr_waddr_o == query_r2_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (exu_live[i] && exu_mem[i].wen) begin
                if (exu_mem[i].rd == query_r1_i) pend1_o = 1'b1;
                if (exu_mem[i].rd == query_r2_i) pend2_o = 1'b1;
            end
            if (lsu_live[i] && lsu_mem[i].wen) begin
                if (lsu_mem[i].rd == query_r1_i) pend1_o = 1'b1;
                if (lsu_mem[i].rd == query_r2_i) pend2_o = 1'b1;
            end
        end
        if (query_r1_i == 5'd0) pend1_o = 1'b0;
        if (query_r2_i == 5'd0) pend2_o = 1'b0;
    end
endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Bench for the write-back unit: directed scenarios plus random traffic checked
// against a queue-based model of the two producers and the retire stream.
module tb_ysyx_25060170_wbu;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exu_valid = 1'b0, exu_wen = 1'b0, lsu_valid = 1'b0, lsu_wen = 1'b0;
    logic [4:0]  exu_rd = '0, lsu_rd = '0, query_r1 = '0, query_r2 = '0;
    logic [31:0] exu_data = '0, lsu_data = '0;
    logic        exu_ready_o, lsu_ready_o, gpr_we_o, pend1_o, pend2_o;
    logic [4:0]  gpr_waddr_o;
    logic [31:0] gpr_wdata_o, commit_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        exq[$];
    ent_t        lsq[$];
    bit          m_last_lsu;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_cnt;

    ysyx_25060170_wbu #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .exu_valid_i(exu_valid), .exu_ready_o(exu_ready_o), .exu_wen_i(exu_wen),
        .exu_rd_i(exu_rd), .exu_data_i(exu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready_o), .lsu_wen_i(lsu_wen),
        .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
        .gpr_we_o(gpr_we_o), .gpr_waddr_o(gpr_waddr_o), .gpr_wdata_o(gpr_wdata_o),
        .query_r1_i(query_r1), .query_r2_i(query_r2),
        .pend1_o(pend1_o), .pend2_o(pend2_o), .commit_cnt_o(commit_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic m_pend(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (exq[i]) if (exq[i].wen && exq[i].rd == q) return 1'b1;
        foreach (lsq[i]) if (lsq[i].wen && lsq[i].rd == q) return 1'b1;
        return m_we && (m_waddr == q);
    endfunction

    // Advance one clock edge, applying the same edge to the model; returns at edge+1.
    task automatic tick();
        bit   ep, lp, pe, pl;
        ent_t e;
        ep = exu_valid && (exq.size() < DEPTH) && !rst;
        lp = lsu_valid && (lsq.size() < DEPTH) && !rst;
        pl = (lsq.size() != 0) && ((exq.size() == 0) || !m_last_lsu);
        pe = (exq.size() != 0) && !pl;
        @(posedge clk);
        if (rst) begin
            exq.delete();
            lsq.delete();
            m_last_lsu = 1'b0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = '0;
        end else begin
            if (pl || pe) begin
                e = pl ? lsq.pop_front() : exq.pop_front();
                m_we = e.wen && (e.rd != 5'd0);
                m_waddr = e.rd;
                m_wdata = e.data;
                m_cnt = m_cnt + 32'd1;
                m_last_lsu = pl;
            end else begin
                m_we = 1'b0;
            end
            if (ep) exq.push_back('{exu_wen, exu_rd, exu_data});
            if (lp) lsq.push_back('{lsu_wen, lsu_rd, lsu_data});
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_vec++;
        if ({exu_ready_o, lsu_ready_o} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready_low: got %b want 00", {exu_ready_o, lsu_ready_o});
        end
        rst = 1'b0;
        query_r1 = 5'd5;
        query_r2 = 5'd0;
        #1;
        n_vec++;
        if ({exu_ready_o, lsu_ready_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o, commit_cnt_o, pend1_o, pend2_o}
            !== {2'b11, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b we=%b wa=%0d wd=%h cnt=%0d pend=%b%b",
                     {exu_ready_o, lsu_ready_o}, gpr_we_o, gpr_waddr_o, gpr_wdata_o,
                     commit_cnt_o, pend1_o, pend2_o);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        query_r1 = 5'd5;
        #1;
        n_vec++;
        if ({exu_ready_o, pend1_o} !== 2'b10) begin
            n_err++;
            $display("FAIL single_c0: got ready/pend %b want 10", {exu_ready_o, pend1_o});
        end
        tick();
        exu_valid = 1'b0;
        #1;
        n_vec++;
        if ({pend1_o, gpr_we_o} !== 2'b10) begin
            n_err++;
            $display("FAIL single_c1: got pend/we %b want 10", {pend1_o, gpr_we_o});
        end
        tick();
        n_vec++;
        if ({pend1_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o} !== {2'b11, 5'd5, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL single_c2: got pend=%b we=%b wa=%0d wd=%h want 1 1 5 deadbeef",
                     pend1_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o);
        end
        tick();
        n_vec++;
        if ({pend1_o, gpr_we_o, commit_cnt_o} !== {2'b00, 32'd1}) begin
            n_err++;
            $display("FAIL single_c3: got pend=%b we=%b cnt=%0d want 0 0 1",
                     pend1_o, gpr_we_o, commit_cnt_o);
        end
    endtask

    task automatic test_x0_wen0();
        bit bad_we, bad_pend;
        do_reset();
        bad_we = 1'b0;
        bad_pend = 1'b0;
        query_r1 = 5'd0;
        query_r2 = 5'd7;
        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd0; exu_data = 32'h1234;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (pend1_o || pend2_o) bad_pend = 1'b1;
            if (gpr_we_o) bad_we = 1'b1;
            tick();
            if (c == 0) begin
                exu_wen = 1'b0; exu_rd = 5'd7; exu_data = 32'h55;
            end else begin
                exu_valid = 1'b0;
            end
        end
        n_vec++;
        if ({bad_we, bad_pend} !== 2'b00) begin
            n_err++;
            $display("FAIL x0_wen0_quiet: got we_seen=%b pend_seen=%b want 0 0", bad_we, bad_pend);
        end
        n_vec++;
        if (commit_cnt_o !== 32'd2) begin
            n_err++;
            $display("FAIL x0_wen0_count: got %0d want 2", commit_cnt_o);
        end
    endtask

    task automatic test_tie();
        logic [4:0] first_rd;
        do_reset();
        lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hA0A0_0003;
        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd4; exu_data = 32'hB0B0_0004;
        tick();
        lsu_valid = 1'b0; exu_valid = 1'b0;
        tick();
        n_vec++;
        if ({gpr_we_o, gpr_waddr_o, gpr_wdata_o} !== {1'b1, 5'd3, 32'hA0A0_0003}) begin
            n_err++;
            $display("FAIL tie1_first: got we=%b wa=%0d wd=%h want 1 3 a0a00003",
                     gpr_we_o, gpr_waddr_o, gpr_wdata_o);
        end
        tick();
        n_vec++;
        if ({gpr_we_o, gpr_waddr_o, gpr_wdata_o} !== {1'b1, 5'd4, 32'hB0B0_0004}) begin
            n_err++;
            $display("FAIL tie1_second: got we=%b wa=%0d wd=%h want 1 4 b0b00004",
                     gpr_we_o, gpr_waddr_o, gpr_wdata_o);
        end
        // Last pop was EXU, so LSU should win the next tie again.
        first_rd = m_last_lsu ? 5'd14 : 5'd13;
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'h13;
        exu_valid = 1'b1; exu_rd = 5'd14; exu_data = 32'h14;
        tick();
        lsu_valid = 1'b0; exu_valid = 1'b0;
        tick();
        n_vec++;
        if ({gpr_we_o, gpr_waddr_o} !== {1'b1, first_rd} || gpr_waddr_o !== 5'd13) begin
            n_err++;
            $display("FAIL tie2_first: got we=%b wa=%0d want 1 13", gpr_we_o, gpr_waddr_o);
        end
        tick();
        n_vec++;
        if ({gpr_we_o, gpr_waddr_o} !== {1'b1, 5'd14}) begin
            n_err++;
            $display("FAIL tie2_second: got we=%b wa=%0d want 1 14", gpr_we_o, gpr_waddr_o);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ldat [3];
        int   idx, got, cyc;
        bit   saw_full, hs;
        do_reset();
        for (int i = 0; i < 3; i++) ldat[i] = $urandom;
        idx = 0; got = 0; cyc = 0; saw_full = 1'b0;
        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd1; exu_data = $urandom;
        lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_rd = 5'd20; lsu_data = ldat[0];
        while (got < 3 && cyc < 40) begin
            #1;
            n_vec++;
            if (lsu_ready_o !== (lsq.size() != DEPTH)) begin
                n_err++;
                $display("FAIL bp_ready c%0d: got %b want %b", cyc, lsu_ready_o, lsq.size() != DEPTH);
            end
            if (!lsu_ready_o) saw_full = 1'b1;
            hs = lsu_valid && lsu_ready_o;
            tick();
            cyc++;
            if (hs) begin
                idx++;
                if (idx == 3) lsu_valid = 1'b0;
                else begin
                    lsu_rd = 5'(20 + idx);
                    lsu_data = ldat[idx];
                end
            end
            exu_rd = 5'(1 + (cyc % 9));
            exu_data = $urandom;
            if (gpr_we_o && gpr_waddr_o >= 5'd20) begin
                n_vec++;
                if ({gpr_waddr_o, gpr_wdata_o} !== {5'(20 + got), ldat[got]}) begin
                    n_err++;
                    $display("FAIL bp_order %0d: got wa=%0d wd=%h want %0d %h",
                             got, gpr_waddr_o, gpr_wdata_o, 20 + got, ldat[got]);
                end
                got++;
            end
        end
        exu_valid = 1'b0;
        n_vec++;
        if ({saw_full, got == 3} !== 2'b11) begin
            n_err++;
            $display("FAIL bp_summary: got saw_full=%b retired=%0d want 1 3", saw_full, got);
        end
    endtask

    task automatic test_reset_mid();
        bit bad_we;
        do_reset();
        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd6; exu_data = 32'h66;
        lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exu_valid = 1'b0; lsu_valid = 1'b0;
        query_r1 = 5'd6; query_r2 = 5'd7;
        #1;
        n_vec++;
        if ({gpr_we_o, exu_ready_o, lsu_ready_o, commit_cnt_o, pend1_o, pend2_o}
            !== {3'b011, 32'd0, 2'b00}) begin
            n_err++;
            $display("FAIL rstmid_state: got we=%b rdy=%b%b cnt=%0d pend=%b%b want 0 11 0 00",
                     gpr_we_o, exu_ready_o, lsu_ready_o, commit_cnt_o, pend1_o, pend2_o);
        end
        bad_we = 1'b0;
        repeat (6) begin
            tick();
            if (gpr_we_o || commit_cnt_o != 32'd0) bad_we = 1'b1;
        end
        n_vec++;
        if (bad_we !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_discard: got write_after_reset=%b want 0", bad_we);
        end
    endtask

    task automatic test_random();
        logic [1:0]  exp_c;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            exu_valid = ($urandom_range(0, 9) < 6);
            lsu_valid = ($urandom_range(0, 9) < 6);
            exu_wen = ($urandom_range(0, 7) != 0);
            lsu_wen = ($urandom_range(0, 7) != 0);
            exu_rd = 5'($urandom_range(0, 7));
            lsu_rd = 5'($urandom_range(0, 7));
            exu_data = $urandom;
            lsu_data = $urandom;
            query_r1 = 5'($urandom_range(0, 7));
            query_r2 = 5'($urandom_range(0, 7));
            #1;
            exp_c = {m_pend(query_r1), m_pend(query_r2)};
            n_vec++;
            if ({exu_ready_o, lsu_ready_o, pend1_o, pend2_o}
                !== {(exq.size() != DEPTH) && !rst, (lsq.size() != DEPTH) && !rst, exp_c}) begin
                n_err++;
                $display("FAIL rand_comb c%0d: got rdy=%b%b pend=%b%b want rdy=%b%b pend=%b",
                         c, exu_ready_o, lsu_ready_o, pend1_o, pend2_o,
                         (exq.size() != DEPTH) && !rst, (lsq.size() != DEPTH) && !rst, exp_c);
            end
            tick();
            n_vec++;
            if ({gpr_we_o, gpr_waddr_o, gpr_wdata_o, commit_cnt_o} !== {m_we, m_waddr, m_wdata, m_cnt}) begin
                n_err++;
                $display("FAIL rand_out c%0d: got we=%b wa=%0d wd=%h cnt=%0d want %b %0d %h %0d",
                         c, gpr_we_o, gpr_waddr_o, gpr_wdata_o, commit_cnt_o,
                         m_we, m_waddr, m_wdata, m_cnt);
            end
        end
        rst = 1'b0;
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.commit_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt_o;
        #1;
        n_vec++;
        if (commit_cnt_o !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_preset: got %h want ffffffff", commit_cnt_o);
        end
        lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        tick();
        lsu_valid = 1'b0;
        tick();
        n_vec++;
        if ({gpr_we_o, commit_cnt_o} !== {1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL wrap_count: got we=%b cnt=%h want 1 00000000", gpr_we_o, commit_cnt_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_x0_wen0();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
